// File: rtl/adc_pkg.sv
// Shared ADC constants and output-side state type.
// Also reused by the thermometer encoder bench.
package adc_pkg;
    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] CODE_MAX = 4'hF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;
endpackage

// File: rtl/adc_round_shift.sv
// Round-half-up divide by 2^LOG2_N of a window sum.
// Purely combinational.
module adc_round_shift
    import adc_pkg::*;
#(
    parameter int LOG2_N = 2
) (
    input  logic [CODE_W+LOG2_N:0] sum,
    output logic [CODE_W-1:0]      avg
);
    localparam int SW = CODE_W + LOG2_N + 1;
    localparam logic [SW-1:0] HALF = SW'(1) << (LOG2_N - 1);

    logic [SW-1:0] rnd;

    assign rnd = sum + HALF;
    // Sum is at most 15*2^LOG2_N, so the quotient fits in CODE_W bits.
    assign avg = CODE_W'(rnd >> LOG2_N);
endmodule

// File: rtl/adc_code_avg.sv
// Windowed mean/min/max of flash ADC codes with a
// single-entry valid/ready output register.
module adc_code_avg
    import adc_pkg::*;
#(
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sample_en,
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] avg_code,
    output logic [CODE_W-1:0] min_code,
    output logic [CODE_W-1:0] max_code,
    output logic              ovr,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun
);
    localparam int AW = CODE_W + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

    logic [CODE_W-1:0] code_q;
    logic              vld_q;
    logic [AW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic [CODE_W-1:0] run_min;
    logic [CODE_W-1:0] run_max;
    logic              run_ovr;

    logic              acc_en;
    logic              done;
    logic [AW:0]       sum;
    logic [CODE_W-1:0] win_avg;
    logic [CODE_W-1:0] win_min;
    logic [CODE_W-1:0] win_max;
    logic              win_ovr;

    out_state_t        state;
    out_state_t        state_n;
    logic              load;
    logic              set_ovr;

    assign acc_en  = vld_q & en;
    assign done    = acc_en & (cnt == LAST);
    assign sum     = {1'b0, acc} + (AW+1)'(code_q);
    assign win_min = (code_q < run_min) ? code_q : run_min;
    assign win_max = (code_q > run_max) ? code_q : run_max;
    assign win_ovr = run_ovr | (code_q == CODE_MAX);

    adc_round_shift #(
        .LOG2_N(LOG2_N)
    ) u_round (
        .sum(sum),
        .avg(win_avg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= sample_en & en;
            if (sample_en && en)
                code_q <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en || done) begin
            acc     <= '0;
            cnt     <= '0;
            run_min <= CODE_MAX;
            run_max <= '0;
            run_ovr <= 1'b0;
        end else if (acc_en) begin
            acc     <= sum[AW-1:0];
            cnt     <= cnt + 1'b1;
            run_min <= win_min;
            run_max <= win_max;
            run_ovr <= win_ovr;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        set_ovr = 1'b0;
        unique case (state)
            EMPTY: begin
                if (done) begin
                    load    = 1'b1;
                    state_n = FULL;
                end
            end
            FULL: begin
                // A same-edge handshake frees the slot for the new result.
                if (done && avg_ready)
                    load = 1'b1;
                else if (done)
                    set_ovr = 1'b1;
                else if (avg_ready)
                    state_n = EMPTY;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            avg_code <= '0;
            min_code <= '0;
            max_code <= '0;
            ovr      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                avg_code <= win_avg;
                min_code <= win_min;
                max_code <= win_max;
                ovr      <= win_ovr;
            end
            if (set_ovr)
                overrun <= 1'b1;
        end
    end

    assign avg_valid = (state == FULL);
endmodule

// File: doc/adc_code_avg.md
# adc_code_avg

Downstream stage of the 4-bit flash ADC thermometer encoder. Captures the encoder's 4-bit binary code (B3..B0) on a sample strobe and accumulates a window of 2^LOG2_N samples. Each window produces a rounded mean code with window min/max and an over-range flag. Results are presented to the digital back end through a valid/ready handshake with a single-entry output register.

## Interface
- LOG2_N, default 2, log2 of the samples per window; legal range 1..4.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  window enable; low aborts the current window and clears the accumulator.
- sample_en  input  1  one-cycle strobe; `code` is captured on an edge where this is high and `en` is high.
- code  input  4  encoder output {B3,B2,B1,B0}.
- avg_code  output  4  rounded window mean.
- min_code  output  4  smallest code in the window.
- max_code  output  4  largest code in the window.
- ovr  output  1  at least one sample in the window equalled 4'hF.
- avg_valid  output  1  output register holds an unconsumed result.
- avg_ready  input  1  consumer accepts the result on an edge where `avg_valid` and `avg_ready` are both high.
- overrun  output  1  sticky; a completed window was dropped because the output register was still full.

## Operation
- Stage 1, capture: on an edge with `sample_en` and `en` high, `code_q` <= `code` and `vld_q` <= 1. Otherwise `vld_q` <= 0.
- Stage 2, accumulate: on an edge with `vld_q` high and `en` high:
  - acc <= acc + code_q;
  - cnt <= cnt + 1;
  - run_min/run_max/run_ovr are updated with code_q.
  - acc is 4+LOG2_N bits wide. cnt is LOG2_N+1 bits wide.
- Window completion is the accumulate edge where cnt == 2^LOG2_N - 1:
  - result = (acc + code_q + 2^(LOG2_N-1)) >> LOG2_N. The adder is 5+LOG2_N bits wide.
  - The result never exceeds 15, so no saturation is needed.
  - min/max/ovr include code_q.
  - acc, cnt, run_min and run_max reset for the next window. run_min resets to 4'hF and run_max to 4'h0.
- State machine, output side:
  - EMPTY -> FULL on window completion; avg_code/min_code/max_code/ovr are loaded.
  - FULL -> EMPTY on handshake with no completion on the same edge.
  - FULL with handshake and completion on the same edge: load the new result and stay FULL. `overrun` is not set.
  - FULL without handshake and with completion: drop the new result, keep the old one, set `overrun`.
- `overrun` clears only on reset.
- `en` low: acc, cnt, run_min, run_max, run_ovr and `vld_q` are cleared on that edge. The output register and handshake are unaffected.
- `sample_en` pulses while `en` is low are ignored.

## Timing
- Reset values: avg_code=0, min_code=0, max_code=0, ovr=0, avg_valid=0, overrun=0. Internally acc=0, cnt=0, vld_q=0, run_min=4'hF, run_max=0.
- Latency: `sample_en` high in cycle t for the last sample of a window -> `avg_valid` high from cycle t+2.
- Throughput: one sample per clock. Back-to-back `sample_en` is legal.
- Outputs are registered and stay stable while `avg_valid` is high and `avg_ready` is low.
- `rst` mid-window or with a held result: everything returns to reset values on that edge. A sample in the pipeline is discarded.
- `avg_ready` while `avg_valid` is low has no effect.

## Structure
- Shared package adc_pkg holds:
  - CODE_W = 4 and CODE_MAX = 4'hF;
  - the output state typedef {EMPTY, FULL}.
  - The encoder testbench reuses these.
- One sub-module, adc_round_shift: combinational, parameterised by LOG2_N, computing (sum + 2^(LOG2_N-1)) >> LOG2_N. It is separately testable.
- Everything else lives in the top module.

## Test plan
- LOG2_N=2, `avg_ready` tied high, codes 3,4,5,6 on consecutive cycles -> avg_code=5, min_code=3, max_code=6, ovr=0, `avg_valid` high for one cycle, 2 cycles after the last strobe.
- Codes 1,1,1,2 -> avg_code=1 (7>>2). Codes 1,2,2,2 -> avg_code=2 (9>>2), which checks rounding.
- Codes 15,15,15,15 -> avg_code=15, ovr=1, min_code=max_code=15.
- `avg_ready` held low across two full windows (2,2,2,2 then 9,9,9,9) -> avg_code stays 2 and overrun=1. Assert `avg_ready` while a third window completes (codes 7) on the same edge -> avg_code=7, valid stays high, and overrun remains 1 (sticky).
- Two samples of 8, then `en` low for 1 cycle, then four samples of 4 -> avg_code=4 and min_code=4; the aborted samples are excluded.
- `rst` asserted during the 3rd sample of a window -> all outputs 0 on the next cycle. The following 4 samples of 10 -> avg_code=10.
